spi_peripheral: RTL and testbench

- SPI mode-0 responder (CPOL=0, CPHA=0, MSB first) clocked entirely by the fabric clock `i_clk`.
- Oversamples the external `i_sclk`, `i_cs_n` and `i_mosi` pins through synchronizers and detects SCLK rising/falling edges in the `i_clk` domain.
- Shifts a `DATA_WIDTH`-bit word in and out per frame slot and exchanges words with user logic through a one-deep transmit buffer and a receive strobe.
- Serves as the far end of our SPI controller, for loopback benches and for FPGA-as-peripheral builds.

---
 rtl/spi_peripheral.sv | 147 ++++++++++++++
 tb/tb_spi_peripheral.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_peripheral.sv
// SPI mode-0 responder running entirely on the fabric clock.
// Pins are oversampled; words move through a one-deep tx buffer and an rx strobe.
module spi_peripheral #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_sclk,
    input  logic                  i_cs_n,
    input  logic                  i_mosi,
    output logic                  o_miso,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic                  i_tx_valid,
    output logic                  o_tx_ready,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_rx_valid,
    output logic                  o_tx_underrun,
    output logic                  o_busy
);
    localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_prev, cs_prev;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

    logic [DATA_WIDTH-1:0]  tx_shift, rx_shift, rx_next, hold_data;
    logic                   hold_full;
    logic [CW-1:0]          bit_cnt;
    logic                   load, shift, sample, abort;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_fall   = ~cs_s & cs_prev;
    assign cs_rise   = cs_s & ~cs_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    // CS rising wins over any SCLK edge seen in the same cycle
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        shift    = 1'b0;
        sample   = 1'b0;
        abort    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (cs_fall) begin
                    state_nx = S_ACTIVE;
                    load     = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (cs_rise) begin
                    state_nx = S_IDLE;
                    abort    = 1'b1;
                end else begin
                    sample = sclk_rise;
                    if (sclk_fall) begin
                        if (bit_cnt == '0) load  = 1'b1;
                        else               shift = 1'b1;
                    end
                end
            end
        endcase
    end

    assign rx_next = {rx_shift[DATA_WIDTH-2:0], mosi_s};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_shift      <= '0;
            rx_shift      <= '0;
            hold_data     <= '0;
            hold_full     <= 1'b0;
            bit_cnt       <= '0;
            o_rx_data     <= '0;
            o_rx_valid    <= 1'b0;
            o_tx_underrun <= 1'b0;
        end else begin
            o_rx_valid    <= 1'b0;
            o_tx_underrun <= load & ~hold_full;
            if (load) begin
                tx_shift  <= hold_full ? hold_data : '0;
                hold_full <= 1'b0;
            end else if (shift) begin
                tx_shift <= tx_shift << 1;
            end else if (abort) begin
                tx_shift <= '0;
            end
            // a write in the load cycle lands after the old contents left
            if (i_tx_valid && !hold_full) begin
                hold_full <= 1'b1;
                hold_data <= i_tx_data;
            end
            if (abort) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
            end else if (sample) begin
                rx_shift <= rx_next;
                if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
                    bit_cnt    <= '0;
                    o_rx_data  <= rx_next;
                    o_rx_valid <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
        end
    end

    assign o_miso     = (state == S_ACTIVE) & tx_shift[DATA_WIDTH-1];
    assign o_busy     = (state == S_ACTIVE);
    assign o_tx_ready = ~hold_full;

endmodule

// File: tb/tb_spi_peripheral.sv
// Scoreboard bench for spi_peripheral acting as an SPI controller
// at sclk = clk/16, checking MISO bits, rx words and handshakes.
module tb_spi_peripheral;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    int urun_cnt = 0;
    int urun_base;
    int snap;
    logic [7:0] exp_q[$];

    spi_peripheral #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_sclk       (sclk),
        .i_cs_n       (cs_n),
        .i_mosi       (mosi),
        .o_miso       (miso),
        .i_tx_data    (tx_data),
        .i_tx_valid   (tx_valid),
        .o_tx_ready   (tx_ready),
        .o_rx_data    (rx_data),
        .o_rx_valid   (rx_valid),
        .o_tx_underrun(tx_underrun),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_underrun) urun_cnt++;
            if (rx_valid) begin
                if (exp_q.size() == 0) chk("rx_spurious", 32'(rx_valid), 0);
                else chk("rx_word", 32'(rx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tx_write(input logic [7:0] d);
        int t;
        t = 0;
        while (!tx_ready && t < 40) begin
            cyc(1);
            t++;
        end
        if (!tx_ready) chk("tx_wr_timeout", 32'(tx_ready), 1);
        tx_data  = d;
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] mo, input logic [7:0] mi,
                        input int nb);
        if (nb == 8) exp_q.push_back(mo);
        for (int i = 0; i < nb; i++) begin
            sclk = 1'b0;
            mosi = mo[7-i];
            cyc(HALF);
            chk($sformatf("miso_b%0d", i), 32'(miso), 32'(mi[7-i]));
            sclk = 1'b1;
            cyc(HALF);
        end
    endtask

    task automatic end_frame(output int s);
        s = urun_cnt;
        sclk = 1'b0;
        cyc(HALF);
        cs_n = 1'b1;
        cyc(2 * HALF);
    endtask

    initial begin
        // reset state
        cyc(3);
        chk("rst_miso", 32'(miso), 0);
        chk("rst_ready", 32'(tx_ready), 1);
        chk("rst_rx_data", 32'(rx_data), 0);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_urun", 32'(tx_underrun), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        cyc(4);

        // basic exchange
        urun_base = urun_cnt;
        tx_write(8'hA5);
        chk("basic_ready_full", 32'(tx_ready), 0);
        cs_n = 1'b0;
        cyc(5);
        chk("basic_ready_load", 32'(tx_ready), 1);
        chk("basic_busy", 32'(busy), 1);
        xfer(8'h3C, 8'hA5, 8);
        end_frame(snap);
        chk("basic_urun", snap - urun_base, 0);
        chk("basic_idle", 32'(busy), 0);

        // back-to-back words
        urun_base = urun_cnt;
        tx_write(8'h81);
        cs_n = 1'b0;
        fork
            xfer(8'h11, 8'h81, 8);
            begin
                cyc(20);
                tx_write(8'h7E);
            end
        join
        xfer(8'h22, 8'h7E, 8);
        end_frame(snap);
        chk("b2b_urun", snap - urun_base, 0);

        // underrun
        urun_base = urun_cnt;
        cs_n = 1'b0;
        cyc(6);
        chk("urun_csfall", urun_cnt - urun_base, 1);
        xfer(8'hFF, 8'h00, 8);
        end_frame(snap);
        chk("urun_once", snap - urun_base, 1);

        // abort after 5 bits, then a clean frame
        tx_write(8'h96);
        cs_n = 1'b0;
        xfer(8'hC3, 8'h96, 5);
        end_frame(snap);
        chk("abort_busy", 32'(busy), 0);
        tx_write(8'h3B);
        cs_n = 1'b0;
        xfer(8'h5A, 8'h3B, 8);
        end_frame(snap);

        // flow control
        urun_base = urun_cnt;
        tx_write(8'h12);
        tx_data  = 8'h34;
        tx_valid = 1'b1;
        cyc(5);
        chk("fc_blocked", 32'(tx_ready), 0);
        cs_n = 1'b0;
        cyc(6);
        tx_valid = 1'b0;
        chk("fc_refilled", 32'(tx_ready), 0);
        xfer(8'hAA, 8'h12, 8);
        xfer(8'h55, 8'h34, 8);
        end_frame(snap);
        chk("fc_urun", snap - urun_base, 0);

        // asynchronous reset mid-word
        tx_write(8'h77);
        cs_n = 1'b0;
        xfer(8'h0F, 8'h77, 4);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_miso", 32'(miso), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ready", 32'(tx_ready), 1);
        chk("arst_rx_data", 32'(rx_data), 0);
        chk("arst_urun", 32'(tx_underrun), 0);
        sclk = 1'b0;
        cs_n = 1'b1;
        cyc(3);
        rst_n = 1'b1;
        cyc(4);
        tx_write(8'hE7);
        cs_n = 1'b0;
        xfer(8'h99, 8'hE7, 8);
        end_frame(snap);

        cyc(10);
        chk("rx_left", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
